// File: rtl/alu_arbiter_32.sv
// Round-robin arbiter sharing one alu_32 between the fetch/branch unit (port 0)
// and the execute unit (port 1), with a watchdog on multi-cycle operations.
module alu_arbiter_32 #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CTRL_W         = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [31:0]       req_op1_0,
  input  logic [31:0]       req_op1_1,
  input  logic [31:0]       req_op2_0,
  input  logic [31:0]       req_op2_1,
  input  logic [CTRL_W-1:0] req_ctrl_0,
  input  logic [CTRL_W-1:0] req_ctrl_1,
  output logic              resp_valid_0,
  output logic              resp_valid_1,
  input  logic              resp_ready_0,
  input  logic              resp_ready_1,
  output logic [31:0]       resp_result,
  output logic [31:0]       resp_extra,
  output logic              resp_error,
  output logic [31:0]       alu_op1,
  output logic [31:0]       alu_op2,
  output logic [CTRL_W-1:0] alu_control,
  output logic              alu_enable,
  output logic              alu_load,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       alu_extra,
  input  logic              alu_done
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_grant;
  logic               r_grant_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_op1;
  logic [31:0]        r_op2;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [31:0]        r_result;
  logic [31:0]        r_extra;
  logic               r_error;
  logic               w_win0;
  logic               w_win1;
  logic               w_resp_ack;
  logic               w_timeout;

  // Arbitration: a lone requester wins; on contention the port not granted last time wins.
  always_comb begin
    w_win0 = 1'b0;
    w_win1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      w_win0 = r_last_grant;
      w_win1 = ~r_last_grant;
    end else begin
      w_win0 = req_valid_0;
      w_win1 = req_valid_1;
    end
  end

  assign w_resp_ack = r_grant_id ? resp_ready_1 : resp_ready_0;
  assign w_timeout  = (r_cnt == CNT_LAST);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win0 || w_win1) w_next = S_ISSUE;
        else                  w_next = S_IDLE;
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (alu_done || w_timeout) w_next = S_RESP;
        else                       w_next = S_WAIT;
      end
      S_RESP: begin
        if (w_resp_ack) w_next = S_IDLE;
        else            w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand latch, grant bookkeeping, watchdog counter and response capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_cnt        <= '0;
      r_op1        <= 32'd0;
      r_op2        <= 32'd0;
      r_ctrl       <= '0;
      r_result     <= 32'd0;
      r_extra      <= 32'd0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win1) begin
            r_op1        <= req_op1_1;
            r_op2        <= req_op2_1;
            r_ctrl       <= req_ctrl_1;
            r_grant_id   <= 1'b1;
            r_last_grant <= 1'b1;
          end else if (w_win0) begin
            r_op1        <= req_op1_0;
            r_op2        <= req_op2_0;
            r_ctrl       <= req_ctrl_0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b0;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          // done takes priority over a coincident timeout
          if (alu_done) begin
            r_result <= alu_result;
            r_extra  <= alu_extra;
            r_error  <= 1'b0;
          end else if (w_timeout) begin
            r_result <= 32'd0;
            r_extra  <= 32'd0;
            r_error  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: r_cnt <= r_cnt;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign req_ready_0  = reset && (r_state == S_IDLE) && w_win0;
  assign req_ready_1  = reset && (r_state == S_IDLE) && w_win1;
  assign resp_valid_0 = (r_state == S_RESP) && !r_grant_id;
  assign resp_valid_1 = (r_state == S_RESP) &&  r_grant_id;
  assign resp_result  = r_result;
  assign resp_extra   = r_extra;
  assign resp_error   = r_error;
  assign alu_op1      = r_op1;
  assign alu_op2      = r_op2;
  assign alu_control  = r_ctrl;
  assign alu_enable   = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign alu_load     = (r_state == S_ISSUE);

endmodule

// File: tb/tb_alu_arbiter_32.sv
// Directed testbench for alu_arbiter_32 with a latency-programmable ALU model.
module tb_alu_arbiter_32;

  logic        clock;
  logic        reset;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_op1_0, req_op1_1, req_op2_0, req_op2_1;
  logic [2:0]  req_ctrl_0, req_ctrl_1;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0, resp_ready_1;
  logic [31:0] resp_result, resp_extra;
  logic        resp_error;
  logic [31:0] alu_op1, alu_op2;
  logic [2:0]  alu_control;
  logic        alu_enable, alu_load;
  logic [31:0] alu_result, alu_extra;
  logic        alu_done;

  int checks   = 0;
  int failures = 0;

  // ALU model: done asserts m_lat cycles after the load cycle; m_lat=0 never completes
  int          m_lat = 1;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_ext = 32'd0;
  logic [7:0]  m_cnt;

  logic [137:0] all_outs;
  assign all_outs = {req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_result,
                     resp_extra, resp_error, alu_op1, alu_op2, alu_control, alu_enable, alu_load};

  alu_arbiter_32 #(.TIMEOUT_CYCLES(64), .CTRL_W(3)) dut (
    .clock(clock), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_op1_0(req_op1_0), .req_op1_1(req_op1_1),
    .req_op2_0(req_op2_0), .req_op2_1(req_op2_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_result(resp_result), .resp_extra(resp_extra), .resp_error(resp_error),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .alu_enable(alu_enable), .alu_load(alu_load),
    .alu_result(alu_result), .alu_extra(alu_extra), .alu_done(alu_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset)          m_cnt <= 8'd0;
    else if (alu_load)   m_cnt <= 8'd1;
    else if (alu_enable) m_cnt <= m_cnt + 8'd1;
    else                 m_cnt <= 8'd0;
  end
  assign alu_done   = alu_enable && !alu_load && (m_lat != 0) && (int'(m_cnt) == m_lat);
  assign alu_result = m_res;
  assign alu_extra  = m_ext;

  // Stimulus only: present a request on one port until it is accepted, then drop it.
  task automatic send(input int port, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, output bit ok);
    ok = 1'b0;
    if (port == 0) begin
      req_valid_0 = 1'b1; req_op1_0 = a; req_op2_0 = b; req_ctrl_0 = c;
    end else begin
      req_valid_1 = 1'b1; req_op1_1 = a; req_op2_1 = b; req_ctrl_1 = c;
    end
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((port == 0) ? req_ready_0 : req_ready_1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    if (port == 0) req_valid_0 = 1'b0;
    else           req_valid_1 = 1'b0;
  endtask

  // Stimulus only: wait for resp_valid on a port, counting enable and WAIT cycles.
  task automatic wait_resp(input int port, output int en_cyc, output int wait_cyc, output bit ok);
    en_cyc = 0; wait_cyc = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((port == 0) ? resp_valid_0 : resp_valid_1) begin
        ok = 1'b1;
        break;
      end
      if (alu_enable) en_cyc++;
      if (alu_enable && !alu_load) wait_cyc++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0; resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    req_op1_0 = 32'd0; req_op1_1 = 32'd0; req_op2_0 = 32'd0; req_op2_1 = 32'd0;
    req_ctrl_0 = 3'd0; req_ctrl_1 = 3'd0;
    #12;
    checks++;
    if (all_outs !== 138'd0) begin
      failures++; $display("FAIL reset_outs got=%h exp=0", all_outs);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (all_outs !== 138'd0) begin
      failures++; $display("FAIL post_reset_idle got=%h exp=0", all_outs);
    end
  endtask

  task automatic test_single_add();
    bit seen_v1;
    @(negedge clock);
    m_lat = 1; m_res = 32'd0; m_ext = 32'd1;
    req_valid_0 = 1'b1; req_op1_0 = 32'hFFFF_FFFF; req_op2_0 = 32'd1; req_ctrl_0 = 3'd1;
    #1;
    checks++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin
      failures++; $display("FAIL add_ready got=%b exp=10", {req_ready_0, req_ready_1});
    end
    @(negedge clock);
    req_valid_0 = 1'b0; req_op1_0 = 32'd0; req_ctrl_0 = 3'd6;
    #1;
    checks++;
    if ({alu_load, alu_enable, alu_op1, alu_op2, alu_control, req_ready_0} !==
        {1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd1, 1'b0}) begin
      failures++; $display("FAIL add_issue got=%b/%b/%h/%h/%0d exp=1/1/ffffffff/1/1",
                           alu_load, alu_enable, alu_op1, alu_op2, alu_control);
    end
    seen_v1 = resp_valid_1;
    @(negedge clock);
    checks++;
    if ({alu_load, alu_enable, resp_valid_0, alu_op1, alu_control} !==
        {1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 3'd1}) begin
      failures++; $display("FAIL add_wait got=%b/%b/%b/%h/%0d exp=0/1/0/ffffffff/1",
                           alu_load, alu_enable, resp_valid_0, alu_op1, alu_control);
    end
    seen_v1 = seen_v1 | resp_valid_1;
    @(negedge clock);
    seen_v1 = seen_v1 | resp_valid_1;
    checks++;
    if ({resp_valid_0, seen_v1, resp_result, resp_extra, resp_error} !==
        {1'b1, 1'b0, 32'd0, 32'd1, 1'b0}) begin
      failures++; $display("FAIL add_resp got=v0=%b v1=%b res=%h ext=%h err=%b exp=1/0/0/1/0",
                           resp_valid_0, seen_v1, resp_result, resp_extra, resp_error);
    end
    resp_ready_0 = 1'b1;
    @(negedge clock);
    resp_ready_0 = 1'b0;
    checks++;
    if ({resp_valid_0, resp_valid_1, alu_enable} !== 3'b000) begin
      failures++; $display("FAIL add_consume got=%b exp=000", {resp_valid_0, resp_valid_1, alu_enable});
    end
  endtask

  task automatic test_contention();
    int n;
    int g[4];
    bit both;
    int exp_g[4] = '{0, 1, 0, 1};
    n = 0; both = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_lat = 1; m_res = 32'h55; m_ext = 32'd0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1; resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    req_op1_0 = 32'h10; req_op1_1 = 32'h20;
    for (int c = 0; c < 200 && n < 4; c++) begin
      #1;
      if (req_ready_0 && req_ready_1) both = 1'b1;
      if (req_ready_0) begin g[n] = 0; n++; end
      else if (req_ready_1) begin g[n] = 1; n++; end
      @(negedge clock);
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    repeat (5) @(negedge clock);
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL contention_count got=%0d exp=4", n);
    end
    checks++;
    if (both !== 1'b0) begin
      failures++; $display("FAIL contention_dual_ready got=%b exp=0", both);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (g[i] !== exp_g[i]) begin
        failures++; $display("FAIL contention_order[%0d] got=%0d exp=%0d", i, g[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_multicycle();
    bit ok, okr;
    int en, wt;
    @(negedge clock);
    m_lat = 20; m_res = 32'h1234_5678; m_ext = 32'h9;
    send(1, 32'h0000_0100, 32'h0000_0200, 3'd5, ok);
    wait_resp(1, en, wt, okr);
    checks++;
    if ({ok, okr} !== 2'b11) begin
      failures++; $display("FAIL multi_handshake got=%b exp=11", {ok, okr});
    end
    checks++;
    if (en !== 21) begin
      failures++; $display("FAIL multi_enable_cycles got=%0d exp=21", en);
    end
    checks++;
    if ({resp_result, resp_extra, resp_error, resp_valid_0, alu_control} !==
        {32'h1234_5678, 32'h9, 1'b0, 1'b0, 3'd5}) begin
      failures++; $display("FAIL multi_resp got=%h/%h/%b/%b/%0d exp=12345678/9/0/0/5",
                           resp_result, resp_extra, resp_error, resp_valid_0, alu_control);
    end
    resp_ready_1 = 1'b1;
    @(negedge clock);
    resp_ready_1 = 1'b0;
    checks++;
    if (resp_valid_1 !== 1'b0) begin
      failures++; $display("FAIL multi_consume got=%b exp=0", resp_valid_1);
    end
  endtask

  task automatic test_timeout();
    bit ok, okr;
    int en, wt;
    @(negedge clock);
    m_lat = 0; m_res = 32'hDEAD_BEEF; m_ext = 32'hCAFE_F00D;
    send(0, 32'd3, 32'd0, 3'd7, ok);
    wait_resp(0, en, wt, okr);
    checks++;
    if ({ok, okr} !== 2'b11) begin
      failures++; $display("FAIL timeout_handshake got=%b exp=11", {ok, okr});
    end
    checks++;
    if (wt !== 64) begin
      failures++; $display("FAIL timeout_wait_cycles got=%0d exp=64", wt);
    end
    checks++;
    if ({resp_error, resp_result, resp_extra} !== {1'b1, 32'd0, 32'd0}) begin
      failures++; $display("FAIL timeout_resp got=%b/%h/%h exp=1/0/0", resp_error, resp_result, resp_extra);
    end
    resp_ready_0 = 1'b1;
    @(negedge clock);
    resp_ready_0 = 1'b0;
    m_lat = 1; m_res = 32'd12; m_ext = 32'd0;
    send(0, 32'd5, 32'd7, 3'd1, ok);
    wait_resp(0, en, wt, okr);
    checks++;
    if ({ok, okr, resp_error, resp_result, resp_extra} !== {1'b1, 1'b1, 1'b0, 32'd12, 32'd0}) begin
      failures++; $display("FAIL after_timeout_resp got=%b%b/%b/%h/%h exp=11/0/c/0",
                           ok, okr, resp_error, resp_result, resp_extra);
    end
    resp_ready_0 = 1'b1;
    @(negedge clock);
    resp_ready_0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok, okr;
    int en, wt;
    @(negedge clock);
    m_lat = 1; m_res = 32'hAAAA_5555; m_ext = 32'd5;
    send(0, 32'd1, 32'd2, 3'd2, ok);
    wait_resp(0, en, wt, okr);
    checks++;
    if ({ok, okr} !== 2'b11) begin
      failures++; $display("FAIL bp_handshake got=%b exp=11", {ok, okr});
    end
    req_valid_1 = 1'b1; req_op1_1 = 32'h0000_BEEF; req_op2_1 = 32'd4; req_ctrl_1 = 3'd3;
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({resp_valid_0, resp_valid_1, req_ready_1, resp_result, resp_extra} !==
          {1'b1, 1'b0, 1'b0, 32'hAAAA_5555, 32'd5}) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b%b%b/%h/%h exp=100/aaaa5555/5", i,
                             resp_valid_0, resp_valid_1, req_ready_1, resp_result, resp_extra);
      end
      @(negedge clock);
    end
    m_lat = 1; m_res = 32'h77; m_ext = 32'd0;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b0;
    @(negedge clock);
    resp_ready_0 = 1'b0;
    #1;
    checks++;
    if ({resp_valid_0, req_ready_1} !== 2'b01) begin
      failures++; $display("FAIL b2b_grant got=%b exp=01", {resp_valid_0, req_ready_1});
    end
    @(negedge clock);
    req_valid_1 = 1'b0;
    wait_resp(1, en, wt, okr);
    checks++;
    if ({okr, alu_op1, resp_result} !== {1'b1, 32'h0000_BEEF, 32'h77}) begin
      failures++; $display("FAIL b2b_resp got=%b/%h/%h exp=1/0000beef/77", okr, alu_op1, resp_result);
    end
    resp_ready_1 = 1'b1;
    @(negedge clock);
    resp_ready_1 = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    @(negedge clock);
    m_lat = 0;
    send(0, 32'd9, 32'd9, 3'd4, ok);
    repeat (5) @(negedge clock);
    checks++;
    if ({ok, alu_enable, alu_load} !== 3'b110) begin
      failures++; $display("FAIL midwait_state got=%b exp=110", {ok, alu_enable, alu_load});
    end
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (all_outs !== 138'd0) begin
      failures++; $display("FAIL midwait_reset_outs got=%h exp=0", all_outs);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin
      failures++; $display("FAIL post_reset_grant got=%b exp=10", {req_ready_0, req_ready_1});
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_multicycle();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
